free_list_ctrl: RTL and testbench
=================================

# free_list_ctrl

Front-end controller for the physical-register Free_List. It merges register releases from two sources, commit retirement (T_old) and squash rollback (T of squashed instructions), into a small release queue. It drains that queue one entry per cycle into the Free_List's single release port (`enable`/`T_old`) and gates dispatch allocation (`dispatch_en`) on free-list occupancy and recovery state. It sits between the ROB/retire stage, the branch-recovery logic, the dispatch stage and Free_List.

## Interface
- `NUM_PHYS_REG`, 64: physical register count. `PR_W = $clog2(NUM_PHYS_REG)`.
- `QDEPTH`, 4: release queue depth, power of two, ≥2.
- `FL_LOW_WM`, 2: dispatch watermark, used only with `FL_CTRL_WATERMARK_EN`.
- `clock`, in, 1: single clock; all state updates on posedge.
- `reset`, in, 1: asynchronous, active-low; `reset==0` clears all state immediately.
- `retire_valid`, in, 1: commit releases `retire_T_old`.
- `retire_T_old`, in, PR_W: register freed by commit.
- `retire_ready`, out, 1: the retire release is accepted this cycle.
- `squash_valid`, in, 1: rollback releases `squash_T`.
- `squash_T`, in, PR_W: register freed by squash walk.
- `squash_ready`, out, 1: the squash release is accepted this cycle.
- `squash_start`, in, 1: one-cycle pulse; recovery begins.
- `squash_done`, in, 1: one-cycle pulse; last squash release has been presented.
- `dispatch_req`, in, 1: dispatch wants one physical register.
- `dispatch_grant`, out, 1: allocation granted; equals `fl_dispatch_en`.
- `fl_num_free`, in, PR_W+1: Free_List `num_free_entries`.
- `fl_empty`, in, 1: Free_List `empty`.
- `fl_enable`, out, 1: drives Free_List `enable`.
- `fl_T_old`, out, PR_W: drives Free_List `T_old`.
- `fl_dispatch_en`, out, 1: drives Free_List `dispatch_en`.
- `q_count`, out, $clog2(QDEPTH)+1: release queue occupancy.
- `recovering`, out, 1: high in states RECOVER and FLUSH.

## Operation
- **Release queue:** circular FIFO with head/tail pointers and `q_count`.
  - `fl_enable = (q_count != 0)`. `fl_T_old = queue[head]`.
  - Free_List always accepts, so a non-empty queue pops every cycle.
- **Release acceptance:** `space = QDEPTH - q_count + (q_count != 0)`.
  - `retire_ready = space >= 1`.
  - `squash_ready = (space >= 2) || (space >= 1 && !retire_valid)`.
  - Accepted entries enqueue at posedge, retire entry first when both are accepted in the same cycle.
  - Enqueue and pop can happen in the same cycle. `q_count` updates by +accepted −popped and never exceeds QDEPTH.
- **FSM states:**
  - RUN: normal operation. `squash_start` moves to RECOVER.
  - RECOVER: dispatch is blocked. `squash_done` moves to FLUSH. If `squash_done` arrives together with `squash_start`, go straight to FLUSH.
  - FLUSH: dispatch is blocked until `q_count == 0`, then return to RUN.
  - `squash_start` in RECOVER or FLUSH is ignored. `squash_done` in RUN is ignored.
- **Dispatch gating:**
  - `dispatch_grant = dispatch_req && state==RUN && !fl_empty && wm_ok`.
  - `wm_ok` is defined under Configuration.
  - Releases and a grant may occur in the same cycle; Free_List handles both.
- **Retire releases:** accepted in every state.

## Timing
- Reset values: queue empty, `q_count=0`, state RUN. `fl_enable`, `fl_T_old`, `fl_dispatch_en`, `dispatch_grant` and `recovering` are all 0. Readies are 1 once `reset` deasserts.
- **Release latency:** an entry accepted at edge N appears on `fl_enable`/`fl_T_old` after edge N. Free_List consumes it at edge N+1 if it is at the head.
- **Throughput:** one release per cycle to Free_List; sustained dual-source input backpressures squash first.
- **Dispatch grant:** combinational, same cycle as `dispatch_req`. Free_List decrements at the next edge.
- **State transitions:** `recovering` rises the cycle after `squash_start` and falls the cycle after FLUSH observes `q_count==0`.
- **Reset mid-operation:** queued releases are discarded and state returns to RUN. Recovery from this case is the upstream's responsibility.

## Configuration
- Macro: `FL_CTRL_WATERMARK_EN`.
  - Defined: `wm_ok = (fl_num_free > FL_LOW_WM)`. This keeps a reserve of registers for in-flight releases.
  - Undefined: `wm_ok = 1`, so grant depends only on `!fl_empty`, state and request.

## Test plan
- **Reset:** drive `reset=0` mid-cycle. Outputs go to 0 immediately, `q_count=0`, `recovering=0`. Release `reset`; `retire_ready=1`.
- **Single retire:** `retire_valid=1, retire_T_old=5` for one cycle. Next cycle `fl_enable=1, fl_T_old=5`; the cycle after, `fl_enable=0`, `q_count=0`.
- **Dual release:** retire T=7 and squash T=9 in the same cycle. `fl_T_old` shows 7 then 9 on consecutive cycles; `q_count` goes 2, 1, 0.
- **Backpressure (QDEPTH=4):** hold both sources valid every cycle. `q_count` never exceeds 4, `squash_ready` drops, and retire is never refused.
- **Recovery:** `dispatch_req=1` throughout with `squash_start`, 3 squash releases, then `squash_done`. `dispatch_grant=0` from the cycle after `squash_start` until the queue drains, then the grant resumes. `recovering` tracks this window.
- **Watermark (macro defined, FL_LOW_WM=2):**
  - `fl_num_free=2`, `dispatch_req=1`: `dispatch_grant=0`.
  - `fl_num_free=3`: grant=1.
  - With the macro undefined, `fl_num_free=1` grants.

Source files
------------

// File: rtl/free_list_ctrl.sv
// Free_List front end: merges commit and squash register releases into a small
// release queue, drains it one entry per cycle, and gates dispatch allocation.
// Optional feature: define FL_CTRL_WATERMARK_EN to hold back dispatch at a low free count.
module free_list_ctrl #(
    parameter int NUM_PHYS_REG = 64,
    parameter int QDEPTH       = 4,
    parameter int FL_LOW_WM    = 2,
    localparam int PR_W        = $clog2(NUM_PHYS_REG),
    localparam int CW          = $clog2(QDEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            retire_valid,
    input  logic [PR_W-1:0] retire_T_old,
    output logic            retire_ready,
    input  logic            squash_valid,
    input  logic [PR_W-1:0] squash_T,
    output logic            squash_ready,
    input  logic            squash_start,
    input  logic            squash_done,
    input  logic            dispatch_req,
    output logic            dispatch_grant,
    input  logic [PR_W:0]   fl_num_free,
    input  logic            fl_empty,
    output logic            fl_enable,
    output logic [PR_W-1:0] fl_T_old,
    output logic            fl_dispatch_en,
    output logic [CW-1:0]   q_count,
    output logic            recovering
);

    localparam int AW = $clog2(QDEPTH);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PR_W-1:0] queue [QDEPTH];
    logic [AW-1:0]   head, tail, tail_p1;
    logic [CW:0]     space;
    logic            pop, retire_acc, squash_acc, wm_ok;

    // The head entry always leaves this cycle, so its slot counts as free.
    assign pop          = (q_count != '0);
    assign space        = (CW+1)'(QDEPTH) - {1'b0, q_count} + (CW+1)'(pop);
    assign retire_ready = (space >= (CW+1)'(1));
    assign squash_ready = (space >= (CW+1)'(2)) || ((space >= (CW+1)'(1)) && !retire_valid);
    assign retire_acc   = retire_valid && retire_ready;
    assign squash_acc   = squash_valid && squash_ready;
    assign tail_p1      = tail + AW'(1);

    assign fl_enable = pop;
    assign fl_T_old  = queue[head];

`ifdef FL_CTRL_WATERMARK_EN
    assign wm_ok = (fl_num_free > (PR_W+1)'(FL_LOW_WM));
`else
    assign wm_ok = 1'b1;
`endif

    assign fl_dispatch_en = dispatch_req && (state == RUN) && !fl_empty && wm_ok;
    assign dispatch_grant = fl_dispatch_en;
    assign recovering     = (state != RUN);

    // Retire entry takes the tail slot first when both sources are accepted together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            q_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                queue[i] <= '0;
            end
        end else begin
            if (retire_acc) begin
                queue[tail] <= retire_T_old;
            end
            if (squash_acc) begin
                queue[retire_acc ? tail_p1 : tail] <= squash_T;
            end
            head    <= head + AW'(pop);
            tail    <= tail + AW'(retire_acc) + AW'(squash_acc);
            q_count <= q_count + CW'(retire_acc) + CW'(squash_acc) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (squash_start) begin
                    state_next = squash_done ? FLUSH : RECOVER;
                end
            end
            RECOVER: begin
                if (squash_done) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (q_count == '0) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Randomized and directed bench for free_list_ctrl against a queue-based reference model.
module tb_free_list_ctrl;

    localparam int NUM_PHYS_REG = 64;
    localparam int QDEPTH       = 4;
    localparam int FL_LOW_WM    = 2;
    localparam int PR_W         = $clog2(NUM_PHYS_REG);
    localparam int CW           = $clog2(QDEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            retire_valid = 1'b0;
    logic [PR_W-1:0] retire_T_old = '0;
    logic            retire_ready;
    logic            squash_valid = 1'b0;
    logic [PR_W-1:0] squash_T = '0;
    logic            squash_ready;
    logic            squash_start = 1'b0;
    logic            squash_done = 1'b0;
    logic            dispatch_req = 1'b0;
    logic            dispatch_grant;
    logic [PR_W:0]   fl_num_free = '0;
    logic            fl_empty = 1'b1;
    logic            fl_enable;
    logic [PR_W-1:0] fl_T_old;
    logic            fl_dispatch_en;
    logic [CW-1:0]   q_count;
    logic            recovering;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pending releases in order, plus recovery phase (0 run, 1 recover, 2 flush).
    int model_q[$];
    int phase = 0;
    bit saw_squash_block = 0;

    free_list_ctrl #(
        .NUM_PHYS_REG(NUM_PHYS_REG),
        .QDEPTH(QDEPTH),
        .FL_LOW_WM(FL_LOW_WM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .retire_valid(retire_valid),
        .retire_T_old(retire_T_old),
        .retire_ready(retire_ready),
        .squash_valid(squash_valid),
        .squash_T(squash_T),
        .squash_ready(squash_ready),
        .squash_start(squash_start),
        .squash_done(squash_done),
        .dispatch_req(dispatch_req),
        .dispatch_grant(dispatch_grant),
        .fl_num_free(fl_num_free),
        .fl_empty(fl_empty),
        .fl_enable(fl_enable),
        .fl_T_old(fl_T_old),
        .fl_dispatch_en(fl_dispatch_en),
        .q_count(q_count),
        .recovering(recovering)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check outputs, then advance the model at the rising edge.
    task automatic applyStimulus(input bit rv, input int rt, input bit sv, input int st,
                                 input bit ss, input bit sd, input bit dr, input int nf, input bit fe);
        int  free_slots;
        bit  exp_rr, exp_sr, wm, exp_grant, r_acc, s_acc;
        @(negedge clock);
        retire_valid = rv;
        retire_T_old = PR_W'(rt);
        squash_valid = sv;
        squash_T     = PR_W'(st);
        squash_start = ss;
        squash_done  = sd;
        dispatch_req = dr;
        fl_num_free  = (PR_W+1)'(nf);
        fl_empty     = fe;
        #1;
        free_slots = QDEPTH - model_q.size() + ((model_q.size() != 0) ? 1 : 0);
        exp_rr = (free_slots >= 1);
        exp_sr = (free_slots >= 2) || (free_slots >= 1 && !rv);
`ifdef FL_CTRL_WATERMARK_EN
        wm = (nf > FL_LOW_WM);
`else
        wm = 1'b1;
`endif
        exp_grant = dr && (phase == 0) && !fe && wm;
        checkOutput("q_count", int'(q_count), model_q.size());
        checkOutput("fl_enable", int'(fl_enable), (model_q.size() != 0) ? 1 : 0);
        if (model_q.size() != 0) checkOutput("fl_T_old", int'(fl_T_old), model_q[0]);
        checkOutput("retire_ready", int'(retire_ready), int'(exp_rr));
        checkOutput("squash_ready", int'(squash_ready), int'(exp_sr));
        checkOutput("dispatch_grant", int'(dispatch_grant), int'(exp_grant));
        checkOutput("fl_dispatch_en", int'(fl_dispatch_en), int'(exp_grant));
        checkOutput("recovering", int'(recovering), (phase != 0) ? 1 : 0);
        if (sv && !exp_sr) saw_squash_block = 1;
        r_acc = rv && exp_rr;
        s_acc = sv && exp_sr;
        @(posedge clock);
        case (phase)
            0: if (ss) phase = sd ? 2 : 1;
            1: if (sd) phase = 2;
            default: if (model_q.size() == 0) phase = 0;
        endcase
        if (model_q.size() != 0) void'(model_q.pop_front());
        if (r_acc) model_q.push_back(rt);
        if (s_acc) model_q.push_back(st);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 40, 0);
    endtask

    task automatic resetMidCycle();
        @(negedge clock);
        retire_valid = 0; squash_valid = 0; dispatch_req = 0;
        squash_start = 0; squash_done = 0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_fl_enable", int'(fl_enable), 0);
        checkOutput("rst_fl_T_old", int'(fl_T_old), 0);
        checkOutput("rst_q_count", int'(q_count), 0);
        checkOutput("rst_recovering", int'(recovering), 0);
        checkOutput("rst_grant", int'(dispatch_grant), 0);
        model_q.delete();
        phase = 0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rst_retire_ready", int'(retire_ready), 1);
    endtask

    initial begin
        $display("[TB] free_list_ctrl bench start");
        #12 reset = 1'b1;

        // Single retire, then dual release with retire ordered first
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 40, 0);
        idleCycle();
        idleCycle();
        applyStimulus(1, 7, 1, 9, 0, 0, 0, 40, 0);
        repeat (3) idleCycle();

        // Sustained dual-source pressure
        for (int i = 0; i < 8; i++) applyStimulus(1, 10 + i, 1, 30 + i, 0, 0, 1, 40, 0);
        checkOutput("bp_squash_blocked", int'(saw_squash_block), 1);
        repeat (5) idleCycle();

        // Recovery window with dispatch requested throughout
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 40, 0);
        applyStimulus(0, 0, 1, 21, 0, 0, 1, 40, 0);
        applyStimulus(1, 3, 1, 22, 0, 0, 1, 40, 0);
        applyStimulus(0, 0, 1, 23, 0, 1, 1, 40, 0);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 1, 40, 0);

        // Simultaneous start/done, and low free counts
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 40, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1, 40, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);

        // Random traffic, interrupted by a mid-operation reset
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, NUM_PHYS_REG - 1),
                          $urandom_range(0, 1), $urandom_range(0, NUM_PHYS_REG - 1),
                          ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 1), $urandom_range(0, NUM_PHYS_REG),
                          ($urandom_range(0, 7) == 0));
            if (i == 300) resetMidCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
